// File: rtl/fft_r22sdf_bfii_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fft_r22sdf_bfii_pkg
// Purpose  : Shared constants and helpers for the R2^2 SDF pipeline stages.
// Revision : 1.0
// ============================================================================
package fft_r22sdf_bfii_pkg;

  localparam int DATA_WIDTH_DEF    = 25;
  localparam int SHIFT_REG_LEN_DEF = 256;
  // Delay lines longer than this are built as RAM with a rotating pointer
  localparam int CHAIN_MAX_LEN     = 32;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << result) < value) result = result + 1;
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_r22sdf_bfii_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fft_r22sdf_bfii_if
// Purpose  : Complex sample stream into and out of the BF-II stage.
// Revision : 1.0
// ============================================================================
interface fft_r22sdf_bfii_if #(
  parameter int DATA_WIDTH = 25
);
  logic                         valid_i;
  logic                         start_i;
  logic signed [DATA_WIDTH-1:0] x_re_i;
  logic signed [DATA_WIDTH-1:0] x_im_i;
  logic signed [DATA_WIDTH-1:0] z_re_o;
  logic signed [DATA_WIDTH-1:0] z_im_o;
  logic                         valid_o;
  logic                         start_o;

  modport slave (
    input  valid_i, start_i, x_re_i, x_im_i,
    output z_re_o, z_im_o, valid_o, start_o
  );

  modport master (
    output valid_i, start_i, x_re_i, x_im_i,
    input  z_re_o, z_im_o, valid_o, start_o
  );
endinterface

`default_nettype wire

// File: rtl/fft_r22sdf_delay.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fft_r22sdf_delay
// Purpose  : Enable-gated WIDTH x LEN delay line; register chain or RAM.
// Revision : 1.0
// ============================================================================
module fft_r22sdf_delay
  import fft_r22sdf_bfii_pkg::*;
#(
  parameter int WIDTH = 25,
  parameter int LEN   = 256
) (
  input  wire logic             clk_i,
  input  wire logic             rst_i,
  input  wire logic             en_i,
  input  wire logic [WIDTH-1:0] d_i,
  output logic      [WIDTH-1:0] q_o
);

  if (LEN <= CHAIN_MAX_LEN) begin : g_chain
    logic [WIDTH-1:0] r_sr [LEN];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < LEN; i++) r_sr[i] <= '0;
      end else if (en_i) begin
        r_sr[0] <= d_i;
        for (int i = 1; i < LEN; i++) r_sr[i] <= r_sr[i-1];
      end
    end

    assign q_o = r_sr[LEN-1];
  end else begin : g_ram
    localparam int c_ptr_w = clog2(LEN);
    logic [WIDTH-1:0]   r_mem [LEN];
    logic [c_ptr_w-1:0] r_ptr;
    logic               r_primed;

    always_ff @(posedge clk_i) begin
      if (en_i) r_mem[r_ptr] <= d_i;
    end

    // RAM contents survive reset; r_primed masks stale words until one full lap
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_ptr    <= '0;
        r_primed <= 1'b0;
      end else if (en_i) begin
        r_ptr <= r_ptr + c_ptr_w'(1);
        if (r_ptr == '1) r_primed <= 1'b1;
      end
    end

    assign q_o = r_primed ? r_mem[r_ptr] : '0;
  end

endmodule

`default_nettype wire

// File: rtl/fft_r22sdf_bfii.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fft_r22sdf_bfii
// Purpose  : Radix-2^2 SDF butterfly type II with -j rotation and block counter.
// Revision : 1.0
// ============================================================================
module fft_r22sdf_bfii
  import fft_r22sdf_bfii_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int SHIFT_REG_LEN = SHIFT_REG_LEN_DEF
) (
  input  wire logic           clk_i,
  input  wire logic           rst_i,
  fft_r22sdf_bfii_if.slave    bus
);

  localparam int c_b     = clog2(SHIFT_REG_LEN);
  localparam int c_cnt_w = c_b + 2;
  localparam logic [c_cnt_w-1:0] c_l = c_cnt_w'(SHIFT_REG_LEN);

  logic        [c_cnt_w-1:0]    r_cnt;
  logic                         r_filled;
  logic signed [DATA_WIDTH-1:0] r_z_re, r_z_im;
  logic                         r_valid, r_start;

  logic        [c_cnt_w-1:0]    w_e;
  logic                         w_s, w_rot;
  logic signed [DATA_WIDTH-1:0] w_xr, w_xi;
  logic signed [DATA_WIDTH-1:0] w_sr_re, w_sr_im;
  logic signed [DATA_WIDTH-1:0] w_sr_in_re, w_sr_in_im;
  logic signed [DATA_WIDTH-1:0] w_out_re, w_out_im;

  assign w_e   = bus.start_i ? '0 : r_cnt;
  assign w_s   = w_e[c_b];
  assign w_rot = w_e[c_b] & w_e[c_b+1];

  // -j * x = (im, -re)
  assign w_xr = w_rot ? bus.x_im_i  : bus.x_re_i;
  assign w_xi = w_rot ? -bus.x_re_i : bus.x_im_i;

  assign w_out_re   = w_s ? w_sr_re + w_xr : w_sr_re;
  assign w_out_im   = w_s ? w_sr_im + w_xi : w_sr_im;
  assign w_sr_in_re = w_s ? w_sr_re - w_xr : w_xr;
  assign w_sr_in_im = w_s ? w_sr_im - w_xi : w_xi;

  fft_r22sdf_delay #(.WIDTH(DATA_WIDTH), .LEN(SHIFT_REG_LEN)) u_delay_re (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (bus.valid_i),
    .d_i   (w_sr_in_re),
    .q_o   (w_sr_re)
  );

  fft_r22sdf_delay #(.WIDTH(DATA_WIDTH), .LEN(SHIFT_REG_LEN)) u_delay_im (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (bus.valid_i),
    .d_i   (w_sr_in_im),
    .q_o   (w_sr_im)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt    <= '0;
      r_filled <= 1'b0;
      r_z_re   <= '0;
      r_z_im   <= '0;
      r_valid  <= 1'b0;
      r_start  <= 1'b0;
    end else if (bus.valid_i) begin
      r_cnt    <= w_e + c_cnt_w'(1);
      r_filled <= r_filled | w_s;
      r_z_re   <= w_out_re;
      r_z_im   <= w_out_im;
      r_valid  <= r_filled | w_s;
      r_start  <= (w_e == c_l);
    end else begin
      r_valid  <= 1'b0;
      r_start  <= 1'b0;
    end
  end

  assign bus.z_re_o  = r_z_re;
  assign bus.z_im_o  = r_z_im;
  assign bus.valid_o = r_valid;
  assign bus.start_o = r_start;

endmodule

`default_nettype wire

// File: tb/tb_fft_r22sdf_bfii.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fft_r22sdf_bfii
// Purpose  : Directed-vector bench for the BF-II stage (DATA_WIDTH=16, L=4).
// Revision : 1.0
// ============================================================================
module tb_fft_r22sdf_bfii;

  localparam int DW = 16;
  localparam int L  = 4;
  localparam int SENTINEL = 12345;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_r22sdf_bfii_if #(.DATA_WIDTH(DW)) bus ();

  fft_r22sdf_bfii #(.DATA_WIDTH(DW), .SHIFT_REG_LEN(L)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cap_re [16];
  int cap_im [16];
  int cap_n, n_sent, start_at, base;
  bit armed, cap_on;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic arm();
    armed  = 1'b1;
    cap_on = 1'b0;
    cap_n  = 0;
    for (int i = 0; i < 16; i++) begin
      cap_re[i] = SENTINEL;
      cap_im[i] = SENTINEL;
    end
  endtask

  task automatic send(input bit st, input int re, input int im);
    bus.valid_i = 1'b1;
    bus.start_i = st;
    bus.x_re_i  = DW'(re);
    bus.x_im_i  = DW'(im);
    @(posedge clk); #1;
    if (bus.start_o) begin
      start_at = n_sent;
      if (armed) begin
        armed  = 1'b0;
        cap_on = 1'b1;
        cap_n  = 0;
      end
    end
    if (cap_on && bus.valid_o && cap_n < 16) begin
      cap_re[cap_n] = int'(bus.z_re_o);
      cap_im[cap_n] = int'(bus.z_im_o);
      cap_n++;
    end
    n_sent++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.valid_i = 1'b0;
      bus.start_i = 1'b0;
      bus.x_re_i  = '0;
      bus.x_im_i  = '0;
      @(posedge clk); #1;
      check("gap_valid_o", int'(bus.valid_o), 0);
      check("gap_start_o", int'(bus.start_o), 0);
    end
  endtask

  task automatic do_reset();
    bus.valid_i = 1'b0;
    bus.start_i = 1'b0;
    bus.x_re_i  = '0;
    bus.x_im_i  = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    armed    = 1'b0;
    cap_on   = 1'b0;
    cap_n    = 0;
    n_sent   = 0;
    start_at = -1;
  endtask

  // Expected capture: all zero except two indexed samples
  task automatic check_cap(input string tag,
                           input int ia, input int ra, input int ima,
                           input int ib, input int rb, input int imb);
    int er, ei;
    check($sformatf("%s_count", tag), cap_n, 16);
    for (int i = 0; i < 16; i++) begin
      er = 0; ei = 0;
      if (i == ia) begin er = ra; ei = ima; end
      if (i == ib) begin er = rb; ei = imb; end
      check($sformatf("%s_re[%0d]", tag, i), cap_re[i], er);
      check($sformatf("%s_im[%0d]", tag, i), cap_im[i], ei);
    end
  endtask

  initial begin
    bus.valid_i = 1'b0;
    bus.start_i = 1'b0;
    bus.x_re_i  = '0;
    bus.x_im_i  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_z_re",    int'(bus.z_re_o),  0);
    check("rst_z_im",    int'(bus.z_im_o),  0);
    check("rst_valid_o", int'(bus.valid_o), 0);
    check("rst_start_o", int'(bus.start_o), 0);

    // Impulse
    do_reset();
    arm();
    for (int i = 0; i < 20; i++) send(i % 16 == 0, (i == 0) ? 100 : 0, 0);
    check("impulse_start_pos", start_at, 4);
    check_cap("impulse", 0, 100, 0, 4, 100, 0);

    // -j rotation at e=12
    do_reset();
    arm();
    for (int i = 0; i < 20; i++)
      send(i % 16 == 0, (i == 12) ? 30 : 0, (i == 12) ? -7 : 0);
    check_cap("rotate", 8, -7, -30, 12, 7, 30);

    // Wrapping sum
    do_reset();
    arm();
    for (int i = 0; i < 20; i++)
      send(i % 16 == 0, (i == 0 || i == 4) ? 32767 : 0, 0);
    check_cap("wrap", 0, -2, 0, 4, 0, 0);

    // Impulse with stalls before e=5 and e=9
    do_reset();
    arm();
    for (int i = 0; i < 20; i++) begin
      if (i == 5 || i == 9) idle(3);
      send(i % 16 == 0, (i == 0) ? 100 : 0, 0);
    end
    check_cap("stall", 0, 100, 0, 4, 100, 0);

    // Realign at e=6: impulse on the realigned sample
    do_reset();
    for (int i = 0; i < 6; i++) send(i == 0, 0, 0);
    arm();
    base = n_sent;
    send(1'b1, 100, 0);
    for (int i = 1; i < 20; i++) send(i == 16, 0, 0);
    check("realign_start_pos", start_at - base, 4);
    check_cap("realign", 0, 100, 0, 4, 100, 0);

    // Asynchronous reset mid-stream at e=10
    do_reset();
    for (int i = 0; i < 10; i++)
      send(i == 0, (i == 0) ? 100 : ((i == 5) ? 7 : 0), (i == 5) ? 3 : 0);
    check("pre_rst_z_re",    int'(bus.z_re_o),  -7);
    check("pre_rst_z_im",    int'(bus.z_im_o),  -3);
    check("pre_rst_valid_o", int'(bus.valid_o), 1);
    #3 rst = 1'b1;
    #1;
    check("async_rst_z_re",    int'(bus.z_re_o),  0);
    check("async_rst_z_im",    int'(bus.z_im_o),  0);
    check("async_rst_valid_o", int'(bus.valid_o), 0);
    @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 0, 0);
      check($sformatf("post_rst_valid_o[%0d]", i), int'(bus.valid_o), 0);
    end
    send(1'b0, 0, 0);
    check("post_rst_first_valid", int'(bus.valid_o), 1);
    check("post_rst_z_re",        int'(bus.z_re_o),  0);
    check("post_rst_z_im",        int'(bus.z_im_o),  0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
